// File: rtl/skew_feeder.sv
// skew_feeder: row buffer plus diagonal skew generator that feeds the A operands
// of a DIM x DIM systolic MAC array. Row r of the array sees its data r cycles
// after row 0, so each diagonal of the array lines up with the B stream.
//
// Build option: define SKEW_STALL_EN to add the `en` input. With it, a FEED step
// advances only on cycles where en=1, and the skewed output holds while stalled.
module skew_feeder #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            WrEn,
  input  logic [$clog2(DIM)-1:0]          Arow,
  input  logic [DIM-1:0][BITS_AB-1:0]     Ain,
  input  logic                            start,
`ifdef SKEW_STALL_EN
  input  logic                            en,
`endif
  output logic [DIM-1:0][BITS_AB-1:0]     Aout,
  output logic                            busy,
  output logic                            done
);

  localparam int AW = $clog2(DIM);
  // Step counter spans 0 .. 2*DIM-2.
  localparam int TW = $clog2(2 * DIM);
  localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_p0;
  state_t                    state_nxt;
  logic [TW-1:0]             t_p0;
  logic [TW-1:0]             t_nxt;
  logic                      adv;
  logic                      wr_ok;
  logic signed [BITS_AB-1:0] mem [DIM][DIM];

`ifdef SKEW_STALL_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  // The store is write-protected for the whole FEED/DONE window so a running
  // feed always sees a consistent matrix.
  assign wr_ok = WrEn && (state_p0 == IDLE);

  // State register and step counter; reset aborts any feed without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      t_p0     <= '0;
    end else begin
      state_p0 <= state_nxt;
      t_p0     <= t_nxt;
    end
  end

  // Next-state, step counter and status flags.
  always_comb begin
    state_nxt = state_p0;
    t_nxt     = t_p0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_p0)
      IDLE: begin
        if (start) begin
          state_nxt = FEED;
          t_nxt     = '0;
        end
      end
      FEED: begin
        busy = 1'b1;
        if (adv) begin
          if (t_p0 == T_LAST) begin
            state_nxt = DONE;
            t_nxt     = '0;
          end else begin
            t_nxt = t_p0 + TW'(1);
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // Row store: reset clears every word; a write lands only when idle and only on
  // a row that exists, so an out-of-range index never aliases onto a real row.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      for (int r = 0; r < DIM; r++) begin
        if (Arow == AW'(r)) begin
          for (int c = 0; c < DIM; c++) begin
            mem[r][c] <= $signed(Ain[c]);
          end
        end
      end
    end
  end

  // Skew tap: during FEED, row r presents column t-r when that column exists,
  // zero otherwise. Driven from registered state only, so no input reaches Aout
  // combinationally, and a stalled counter naturally freezes the output.
  always_comb begin
    Aout = '0;
    if (state_p0 == FEED) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (t_p0 == TW'(r + c)) begin
            Aout[r] = mem[r][c];
          end
        end
      end
    end
  end

  // Sanity properties: done implies busy; nothing is driven outside FEED.
  assert property (@(posedge clk) disable iff (rst) done |-> busy);
  assert property (@(posedge clk) disable iff (rst) (state_p0 != FEED) |-> (Aout == '0));

endmodule

// File: tb/tb_skew_feeder.sv
// Testbench for skew_feeder (DIM=8, BITS_AB=8). Expected outputs come from a
// matrix model and the diagonal rule Aout[r] = A[r][t-r].
module tb_skew_feeder;
  localparam int DIM = 8;
  localparam int B   = 8;
  localparam int NT  = 2 * DIM - 1;

  typedef logic [DIM-1:0][B-1:0] vec_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   WrEn;
  logic [$clog2(DIM)-1:0] Arow;
  vec_t                   Ain;
  logic                   start;
  vec_t                   Aout;
  logic                   busy;
  logic                   done;
`ifdef SKEW_STALL_EN
  logic                   en;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [B-1:0] model [DIM][DIM];
  vec_t         cap [NT];

  always #5 clk = ~clk;

  skew_feeder #(.DIM(DIM), .BITS_AB(B)) dut (
    .clk  (clk),
    .rst  (rst),
    .WrEn (WrEn),
    .Arow (Arow),
    .Ain  (Ain),
    .start(start),
`ifdef SKEW_STALL_EN
    .en   (en),
`endif
    .Aout (Aout),
    .busy (busy),
    .done (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t expect_at(int t);
    vec_t v = '0;
    for (int r = 0; r < DIM; r++) begin
      int k = t - r;
      if (k >= 0 && k < DIM) v[r] = model[r][k];
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        model[r][c] = '0;
  endtask

  task automatic write_row(int r, vec_t d);
    WrEn = 1'b1;
    Arow = ($clog2(DIM))'(r);
    Ain  = d;
    tick();
    WrEn = 1'b0;
    for (int c = 0; c < DIM; c++) model[r][c] = d[c];
  endtask

  task automatic load_profile();
    vec_t d;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) d[c] = B'(8 * r + c + 1);
      write_row(r, d);
    end
  endtask

  // One feed: pulse start, check every FEED cycle against the model, then DONE and
  // return to IDLE. Optional injections: write at ws_t, start at st_t, stall of
  // stall_n cycles at stall_t, reset at rst_t, start during DONE.
  task automatic feed(string nm, int ws_t, int st_t, int stall_t, int stall_n,
                      int rst_t, bit st_done);
    int   t = 0;
    int   stalled = 0;
    bit   hold;
    vec_t ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    WrEn  = 1'b0;
    while (t < NT) begin
      ev = expect_at(t);
      n_total++;
      if (Aout !== ev) $display("FAIL %s aout t=%0d: got %h want %h", nm, t, Aout, ev);
      else n_pass++;
      n_total++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL %s status t=%0d: got busy=%b done=%b want busy=1 done=0", nm, t, busy, done);
      else n_pass++;
      cap[t] = Aout;
      if (t == rst_t) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        n_total++;
        if (Aout !== '0 || busy !== 1'b0 || done !== 1'b0)
          $display("FAIL %s after_rst: got aout=%h busy=%b done=%b want 0 0 0", nm, Aout, busy, done);
        else n_pass++;
        for (int i = 0; i < NT + 4; i++) begin
          tick();
          n_total++;
          if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s no_done i=%0d: got busy=%b done=%b want 0 0", nm, i, busy, done);
          else n_pass++;
        end
        return;
      end
      if (t == ws_t) begin
        WrEn = 1'b1;
        Arow = '0;
        Ain  = {DIM{8'h55}};
      end
      if (t == st_t) start = 1'b1;
      hold = (t == stall_t) && (stalled < stall_n);
`ifdef SKEW_STALL_EN
      en = !hold;
`endif
      tick();
      WrEn  = 1'b0;
      start = 1'b0;
`ifdef SKEW_STALL_EN
      en = 1'b1;
`endif
      if (hold) stalled++;
      else t++;
    end
    n_total++;
    if (Aout !== '0 || busy !== 1'b1 || done !== 1'b1)
      $display("FAIL %s done_cycle: got aout=%h busy=%b done=%b want 0 1 1", nm, Aout, busy, done);
    else n_pass++;
    if (st_done) start = 1'b1;
`ifdef SKEW_STALL_EN
    en = 1'b0;
`endif
    tick();
    start = 1'b0;
`ifdef SKEW_STALL_EN
    en = 1'b1;
`endif
    n_total++;
    if (Aout !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s idle_after: got aout=%h busy=%b done=%b want 0 0 0", nm, Aout, busy, done);
    else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL %s no_requeue: got busy=%b want 0", nm, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    vec_t d;
    d = {$urandom, $urandom};
    rst = 1'b1; WrEn = 1'b1; Arow = 3'd1; Ain = d; start = 1'b1;
    tick();
    rst = 1'b0; WrEn = 1'b0; start = 1'b0;
    model_clear();
    n_total++;
    if (Aout !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_out: got aout=%h busy=%b done=%b want 0 0 0", Aout, busy, done);
    else n_pass++;
    feed("reset_mem", -1, -1, -1, 0, -1, 1'b0);
  endtask

  task automatic test_skew_profile();
    vec_t e;
    load_profile();
    feed("profile", -1, -1, -1, 0, -1, 1'b0);
    e = '0; e[0] = 8'd1;
    n_total++;
    if (cap[0] !== e) $display("FAIL profile_t0: got %h want %h", cap[0], e);
    else n_pass++;
    n_total++;
    if (cap[7][0] !== 8'd8 || cap[7][7] !== 8'd57)
      $display("FAIL profile_t7: got a0=%0d a7=%0d want 8 57", cap[7][0], cap[7][7]);
    else n_pass++;
    e = '0; e[7] = 8'd64;
    n_total++;
    if (cap[14] !== e) $display("FAIL profile_t14: got %h want %h", cap[14], e);
    else n_pass++;
  endtask

  task automatic test_sign();
    vec_t d = '0;
    d[0] = 8'h80; d[1] = 8'hFF; d[2] = 8'h7F;
    write_row(3, d);
    feed("sign", -1, -1, -1, 0, -1, 1'b0);
    n_total++;
    if ($signed(cap[3][3]) !== -8'sd128 || $signed(cap[4][3]) !== -8'sd1 || cap[5][3] !== 8'h7F)
      $display("FAIL sign: got %0d %0d %0d want -128 -1 127",
               $signed(cap[3][3]), $signed(cap[4][3]), $signed(cap[5][3]));
    else n_pass++;
  endtask

  task automatic test_write_protect();
    logic [B-1:0] orig0 = model[0][0];
    feed("wprot_run", 2, 6, -1, 0, -1, 1'b1);
    feed("wprot_next", -1, -1, -1, 0, -1, 1'b0);
    n_total++;
    if (cap[0][0] !== orig0) $display("FAIL wprot_row0: got %h want %h", cap[0][0], orig0);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    vec_t d;
    d = {$urandom, $urandom};
    d[0] = 8'd9;
    WrEn = 1'b1; Arow = '0; Ain = d;
    for (int c = 0; c < DIM; c++) model[0][c] = d[c];
    feed("same_cycle", -1, -1, -1, 0, -1, 1'b0);
    n_total++;
    if (cap[0][0] !== 8'd9) $display("FAIL same_cycle_t0: got %0d want 9", cap[0][0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int nw = $urandom_range(1, DIM);
      for (int i = 0; i < nw; i++) begin
        vec_t d;
        d = {$urandom, $urandom};
        write_row($urandom_range(0, DIM - 1), d);
      end
      feed("random", $urandom_range(0, NT - 1), $urandom_range(0, NT - 1), -1, 0, -1, k[0]);
    end
  endtask

  task automatic test_reset_mid();
    load_profile();
    feed("rst_mid", -1, -1, -1, 0, 5, 1'b0);
    feed("rst_cleared", -1, -1, -1, 0, -1, 1'b0);
  endtask

`ifdef SKEW_STALL_EN
  task automatic test_stall();
    load_profile();
    en = 1'b0;
    feed("stall", -1, -1, 4, 3, -1, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b0; WrEn = 1'b0; Arow = '0; Ain = '0; start = 1'b0;
`ifdef SKEW_STALL_EN
    en = 1'b1;
`endif
    model_clear();
    test_reset();
    test_skew_profile();
    test_sign();
    test_write_protect();
    test_same_cycle();
    test_random();
    test_reset_mid();
`ifdef SKEW_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
